uart_frame_ctrl: RTL and testbench

- Frame sequencer behind the UART byte receiver. Consumes its one-cycle `rdy` pulse and `data_o` byte, and assembles framed order messages into a local payload buffer.
- Frame format: SYNC, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
- Presents each validated frame to the order-handling logic through a hold/ack handshake and a registered read port.
- Flags malformed, corrupt or stalled frames.

---
 rtl/uart_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Purpose: frame sequencer behind the UART byte receiver; assembles SYNC/LEN/payload/CHK
//          frames into a local buffer and holds each validated frame until the consumer acks.
// Latency: frame_valid/frame_len one cycle after the CHK byte; rd_data one cycle after rd_addr.
// Backpressure: none toward the receiver; bytes arriving while a frame is held are dropped and counted.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   rx_rdy, rx_data     one-cycle byte strobe and byte from the UART receiver
//   frame_valid/len     validated frame held in buffer, payload length 1..MAX_LEN
//   frame_ack           consumer releases the held frame
//   rd_addr, rd_data    registered payload read port
//   busy                frame reception in progress (LEN, PAYLOAD, CHK)
//   err_chk/len/timeout one-cycle error pulses
//   drop_cnt            saturating count of bytes dropped while holding
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          MAX_LEN      = 16,
  parameter logic [17:0] TIMEOUT_CLKS = 18'd208320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       frame_valid,
  output logic [4:0] frame_len,
  input  logic       frame_ack,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [4:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [17:0] tmo_q, tmo_d;
  logic        fv_q, fv_d;
  logic [4:0]  flen_q, flen_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        err_chk_q, err_chk_d;
  logic        err_len_q, err_len_d;
  logic        err_tmo_q, err_tmo_d;
  logic [7:0]  drop_q, drop_d;
  logic        buf_we;
  logic        in_frame;
  logic        tmo_hit;
  logic [7:0]  mem_q [MAX_LEN];

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // Expiry is the edge at which the counter would reach TIMEOUT_CLKS; a byte
  // on that same cycle wins and is processed normally.
  assign tmo_hit  = in_frame && !rx_rdy && (tmo_q >= TIMEOUT_CLKS - 18'd1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    fv_d      = fv_q;
    flen_d    = flen_q;
    drop_d    = drop_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    buf_we    = 1'b0;

    // Counter clears on every byte and outside reception; saturates rather than wraps.
    tmo_d = tmo_q;
    if (rx_rdy || !in_frame) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + 18'd1;
    end

    rd_data_d = (int'(rd_addr) < MAX_LEN) ? mem_q[rd_addr] : 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (rx_rdy && (rx_data == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_rdy) begin
          if ((rx_data == 8'h00) || (int'(rx_data) > MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data[4:0];
            acc_d   = rx_data;  // checksum covers LEN as well as the payload
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_rdy) begin
          buf_we = 1'b1;
          acc_d  = acc_q ^ rx_data;
          if ({1'b0, idx_q} == len_q - 5'd1) begin
            state_d = S_CHK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_rdy) begin
          if (rx_data == acc_q) begin
            fv_d    = 1'b1;
            flen_d  = len_q;
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        // Buffer is owned by the consumer here: incoming bytes are only counted.
        if (rx_rdy && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        if (frame_ack) begin
          fv_d    = 1'b0;
          flen_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      fv_q      <= 1'b0;
      flen_q    <= '0;
      rd_data_q <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      fv_q      <= fv_d;
      flen_q    <= flen_d;
      rd_data_q <= rd_data_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      drop_q    <= drop_d;
    end
  end

  // Payload storage has no reset; a reset cycle only suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && buf_we) mem_q[idx_q] <= rx_data;
  end

  assign frame_valid = fv_q;
  assign frame_len   = flen_q;
  assign rd_data     = rd_data_q;
  assign busy        = in_frame;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Purpose: randomized scoreboard bench for uart_frame_ctrl with a frame-level reference model.
// Latency: expects frame_valid one cycle after CHK, rd_data one cycle after rd_addr.
// Backpressure: models bytes received while a frame is held as dropped (saturating count).
module tb_uart_frame_ctrl;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic [7:0] rd_data;
  logic       busy, err_chk, err_len, err_timeout;
  logic [7:0] drop_cnt;

  uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(18'(T))) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err_chk(err_chk),
    .err_len(err_len), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_len_q[$];          // expected frame_len of each presented frame
  int exp_err_q[$];          // 1=checksum 2=length 3=timeout
  logic [7:0] exp_rd_q[$];
  logic rd_req = 1'b0;
  bit holding = 0;
  int drop_exp = 0;
  logic [7:0] held[16];      // model of buffer contents
  logic [7:0] tx_pl[16];     // payload of the frame being sent
  bit   pend;
  logic fv_prev = 1'b0;
  int   code;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic note_unexpected(input string what);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", what);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_rdy = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    if (holding && drop_exp < 255) drop_exp++;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  // Sends SYNC, LEN, payload, CHK (or just SYNC, LEN for an illegal length)
  // and records what the consumer side should see.
  task automatic send_frame(input int len, input logic [7:0] chk_mask);
    logic [7:0] chk;
    bit was_holding;
    was_holding = holding;
    chk = 8'(len);
    if (!was_holding) begin
      if (len == 0 || len > 16) exp_err_q.push_back(2);
      else if (chk_mask != 8'h00) exp_err_q.push_back(1);
      else exp_len_q.push_back(len);
    end
    send_byte(8'hA5); gap(); send_byte(8'(len));
    if (len == 0 || len > 16) return;
    for (int i = 0; i < len; i++) begin
      gap(); send_byte(tx_pl[i]);
      chk = chk ^ tx_pl[i];
      if (!was_holding) held[i] = tx_pl[i];
    end
    gap(); send_byte(chk ^ chk_mask);
    if (!was_holding && chk_mask == 8'h00) holding = 1;
  endtask

  task automatic read_check(input int addr);
    @(posedge clk); #1;
    rd_addr = 4'(addr); rd_req = 1'b1;
    exp_rd_q.push_back(held[addr]);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic ack();
    @(posedge clk); #1; frame_ack = 1'b1;
    @(posedge clk); #1; frame_ack = 1'b0;
    holding = 0;
    check("valid_after_ack", frame_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_len"}, frame_len, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_errs"}, {err_chk, err_len, err_timeout}, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a frame, an error or read data.
  initial begin
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        if (exp_rd_q.size() == 0) note_unexpected("rd_data_unexpected");
        else check("rd_data", rd_data, exp_rd_q.pop_front());
      end
      if (frame_valid === 1'b1 && fv_prev !== 1'b1) begin
        if (exp_len_q.size() == 0) note_unexpected("frame_unexpected");
        else check("frame_len", frame_len, exp_len_q.pop_front());
      end
      fv_prev = frame_valid;
      if (err_chk === 1'b1 || err_len === 1'b1 || err_timeout === 1'b1) begin
        code = (err_chk === 1'b1 ? 1 : 0) + (err_len === 1'b1 ? 2 : 0) + (err_timeout === 1'b1 ? 3 : 0);
        if ((err_chk & err_len) | (err_chk & err_timeout) | (err_len & err_timeout)) code = 9;
        if (exp_err_q.size() == 0) note_unexpected("error_unexpected");
        else check("error_kind", code, exp_err_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    int len;
    int kind;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Good frame A5 03 11 22 33 03
    tx_pl[0] = 8'h11; tx_pl[1] = 8'h22; tx_pl[2] = 8'h33;
    send_frame(3, 8'h00);
    check("good_valid", frame_valid, 1);
    check("good_len", frame_len, 3);
    for (int i = 0; i < 3; i++) read_check(i);
    ack();

    // Checksum sent as 04 instead of 03
    send_frame(3, 8'h07);
    check("badchk_valid", frame_valid, 0);
    check("badchk_busy", busy, 0);

    // Illegal lengths, then a one-byte frame
    send_frame(0, 8'h00);
    send_frame(17, 8'h00);
    check("badlen_busy", busy, 0);
    tx_pl[0] = 8'h7E;
    send_frame(1, 8'h00);
    check("len1_valid", frame_valid, 1);
    check("len1_len", frame_len, 1);
    read_check(0);
    ack();

    // Resync through garbage
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    tx_pl[0] = 8'h42;
    send_frame(1, 8'h00);
    check("resync_valid", frame_valid, 1);
    read_check(0);
    ack();

    // Inter-byte timeout
    exp_err_q.push_back(3);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    n = 0; got = 0;
    for (int k = 0; k < 3 * T && !got; k++) begin
      @(posedge clk); #1;
      n++;
      if (err_timeout) got = 1;
    end
    check("timeout_latency", got ? n : -1, T);
    @(posedge clk); #1;
    check("timeout_busy", busy, 0);

    // Byte landing on the expiry edge suppresses the timeout
    exp_len_q.push_back(2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    repeat (T - 2) @(posedge clk);
    send_byte(8'h22);
    send_byte(8'h02 ^ 8'h11 ^ 8'h22);
    held[0] = 8'h11; held[1] = 8'h22; holding = 1;
    check("expiry_byte_valid", frame_valid, 1);
    read_check(1);
    ack();

    // Hold and drop
    tx_pl[0] = 8'hC3; tx_pl[1] = 8'h3C; tx_pl[2] = 8'h99;
    send_frame(3, 8'h00);
    tx_pl[0] = 8'h01; tx_pl[1] = 8'h02; tx_pl[2] = 8'h03;
    send_frame(3, 8'h00);
    check("drop_six", drop_cnt, 6);
    check("drop_model", drop_cnt, drop_exp);
    for (int i = 0; i < 3; i++) read_check(i);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom));
    check("drop_saturate", drop_cnt, 255);
    check("hold_valid", frame_valid, 1);
    ack();

    // Reset mid-payload
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drop_exp = 0;
    check_all_zero("midreset");
    tx_pl[0] = 8'h5A; tx_pl[1] = 8'hA5;
    send_frame(2, 8'h00);
    check("postreset_valid", frame_valid, 1);
    read_check(0); read_check(1);
    ack();

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 2)) begin
        send_byte(8'($urandom_range(0, 8'hA4)));
      end
      kind = $urandom_range(0, 7);
      len = (kind == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255))
                        : $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) tx_pl[i] = 8'($urandom);
      send_frame(len, (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
      if (holding) begin
        check("rand_valid", frame_valid, 1);
        for (int r = 0; r < 3; r++) read_check($urandom_range(0, len - 1));
        repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
        check("rand_drop", drop_cnt, drop_exp);
        ack();
      end else begin
        check("rand_idle_valid", frame_valid, 0);
      end
    end

    repeat (4) @(posedge clk);
    check("frames_left", exp_len_q.size(), 0);
    check("errors_left", exp_err_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
